// File: rtl/gray_seq_decoder.sv
// gray_seq_decoder: Gray-code sample tracker with direction, step-error and relock FSM.
// Ports: clk/rst_n (async active-low), EN enable, Din Gray sample, din_valid strobe,
// clr sync clear; Dout binary value, valid result pulse, dir last step direction,
// step_err non-adjacency pulse, err_cnt saturating error count, locked (state TRACK).
module gray_seq_decoder #(
  parameter int RELOCK = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic [3:0] Din,
  input  logic       din_valid,
  input  logic       clr,
  output logic [3:0] Dout,
  output logic       valid,
  output logic       dir,
  output logic       step_err,
  output logic [3:0] err_cnt,
  output logic       locked
);
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;
  state_t     state_q, state_d;
  logic [3:0] prev_q, prev_d, dout_q, dout_d, err_cnt_q, err_cnt_d;
  logic [2:0] relock_q, relock_d;
  logic       valid_q, valid_d, dir_q, dir_d, step_err_q, step_err_d;
  logic [3:0] bin, diff;
  logic       acc, adj, jump, up;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_q     <= 4'd0;
      relock_q   <= 3'd0;
      dout_q     <= 4'd0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      relock_q   <= relock_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end
  always_comb begin
    bin  = {Din[3], ^Din[3:2], ^Din[3:1], ^Din};
    diff = Din ^ prev_q;
    adj  = $onehot(diff);
    jump = (diff != 4'd0) && !adj;
    // Dout always holds the binary of the previous accepted sample, so it serves as the reference
    up   = bin == 4'(dout_q + 4'd1);
    acc  = EN && din_valid && !clr;
    state_d    = state_q;
    prev_d     = prev_q;
    relock_d   = relock_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    dir_d      = dir_q;
    step_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (clr) begin
      state_d   = IDLE;
      err_cnt_d = 4'd0;
      relock_d  = 3'd0;
    end else if (acc) begin
      dout_d  = bin;
      prev_d  = Din;
      valid_d = 1'b1;
      if (state_q == IDLE) begin
        state_d = TRACK;
      end else if (adj) begin
        dir_d = up;
        if (state_q == FAULT) begin
          relock_d = (int'(relock_q) + 1 >= RELOCK) ? 3'd0 : relock_q + 3'd1;
          state_d  = (int'(relock_q) + 1 >= RELOCK) ? TRACK : FAULT;
        end
      end else if (jump) begin
        step_err_d = 1'b1;
        err_cnt_d  = (err_cnt_q == 4'd15) ? 4'd15 : err_cnt_q + 4'd1;
        relock_d   = 3'd0;
        state_d    = FAULT;
      end
    end
  end
  always_comb begin
    Dout     = dout_q;
    valid    = valid_q;
    dir      = dir_q;
    step_err = step_err_q;
    err_cnt  = err_cnt_q;
    locked   = state_q == TRACK;
  end
endmodule

// File: tb/tb_gray_seq_decoder.sv
// tb_gray_seq_decoder: directed bench with a behavioural reference model and per-cycle compare.
module tb_gray_seq_decoder;
  localparam int RL = 2;
  logic       clk = 1'b0;
  logic       rst_n, EN, din_valid, clr;
  logic [3:0] Din;
  logic [3:0] Dout, err_cnt;
  logic       valid, dir, step_err, locked;
  int checks = 0;
  int failures = 0;

  gray_seq_decoder #(.RELOCK(RL)) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .Din(Din), .din_valid(din_valid), .clr(clr),
    .Dout(Dout), .valid(valid), .dir(dir), .step_err(step_err), .err_cnt(err_cnt), .locked(locked)
  );

  always #5 clk = ~clk;

  function automatic int g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  function automatic int popc(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_mode 0 = no history, 1 = locked, 2 = recovering
  int         m_mode, m_rl, m_dout, m_err, nb, pc;
  logic [3:0] m_prev;
  logic       m_valid, m_dir, m_serr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_rl = 0; m_dout = 0; m_err = 0; m_prev = 4'd0;
      m_valid = 1'b0; m_dir = 1'b0; m_serr = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_serr  = 1'b0;
      if (clr) begin
        m_mode = 0; m_err = 0; m_rl = 0;
      end else if (EN && din_valid) begin
        nb = g2b(Din);
        pc = popc(Din ^ m_prev);
        m_valid = 1'b1;
        if (m_mode == 0) m_mode = 1;
        else if (pc == 1) begin
          m_dir = (nb == (m_dout + 1) % 16);
          if (m_mode == 2) begin
            m_rl++;
            if (m_rl >= RL) begin m_mode = 1; m_rl = 0; end
          end
        end else if (pc >= 2) begin
          m_serr = 1'b1;
          m_err  = (m_err >= 15) ? 15 : m_err + 1;
          m_rl   = 0;
          m_mode = 2;
        end
        m_dout = nb;
        m_prev = Din;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_dout", int'(Dout), m_dout);
    chk("m_valid", int'(valid), int'(m_valid));
    chk("m_dir", int'(dir), int'(m_dir));
    chk("m_step_err", int'(step_err), int'(m_serr));
    chk("m_err_cnt", int'(err_cnt), m_err);
    chk("m_locked", int'(locked), int'(m_mode == 1));
  end

  task automatic drv(input logic en, input logic dv, input logic c, input logic [3:0] g);
    EN = en; din_valid = dv; clr = c; Din = g;
    @(negedge clk);
  endtask

  task automatic smp(input logic [3:0] g);
    drv(1'b1, 1'b1, 1'b0, g);
  endtask

  task automatic do_clr();
    drv(1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  logic [3:0] fwd [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                           4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                           4'b0000};
  logic [3:0] rev [4] = '{4'b0000, 4'b1000, 4'b1001, 4'b1011};

  initial begin
    rst_n = 1'b0; EN = 1'b0; din_valid = 1'b0; clr = 1'b0; Din = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_dout", int'(Dout), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      smp(fwd[i]);
      chk("fwd_dout", int'(Dout), i % 16);
      chk("fwd_valid", int'(valid), 1);
      chk("fwd_dir", int'(dir), int'(i > 0));
      chk("fwd_step_err", int'(step_err), 0);
      chk("fwd_locked", int'(locked), 1);
    end
    do_clr();
    for (int i = 0; i < 4; i++) begin
      smp(rev[i]);
      if (i > 0) begin
        chk("rev_dout", int'(Dout), 16 - i);
        chk("rev_dir", int'(dir), 0);
        chk("rev_step_err", int'(step_err), 0);
      end
    end
    do_clr();
    smp(4'b0001);
    smp(4'b0100);
    chk("jmp_dout", int'(Dout), 7);
    chk("jmp_step_err", int'(step_err), 1);
    chk("jmp_err_cnt", int'(err_cnt), 1);
    chk("jmp_locked", int'(locked), 0);
    smp(4'b0101);
    chk("relock1_locked", int'(locked), 0);
    smp(4'b0111);
    chk("relock2_dout", int'(Dout), 5);
    chk("relock2_dir", int'(dir), 0);
    chk("relock2_locked", int'(locked), 1);
    do_clr();
    smp(4'b0001);
    smp(4'b0011);
    chk("pre_rep_dir", int'(dir), 1);
    smp(4'b0011);
    chk("rep_dout", int'(Dout), 2);
    chk("rep_valid", int'(valid), 1);
    chk("rep_dir", int'(dir), 1);
    chk("rep_step_err", int'(step_err), 0);
    do_clr();
    smp(4'b0000); smp(4'b0011); smp(4'b0001); smp(4'b0001);
    chk("fault_rep_locked", int'(locked), 0);
    smp(4'b0000);
    chk("fault_relock_locked", int'(locked), 1);
    do_clr();
    smp(4'b0000); smp(4'b0011); smp(4'b0001); smp(4'b0111); smp(4'b0110);
    chk("fault_jump_locked", int'(locked), 0);
    smp(4'b0100);
    chk("fault_jump_relock", int'(locked), 1);
    do_clr();
    for (int i = 0; i < 20; i++) begin
      smp((i % 2 == 0) ? 4'b0000 : 4'b0101);
      chk("sat_err_cnt", int'(err_cnt), (i > 15) ? 15 : i);
    end
    chk("sat_step_err", int'(step_err), 1);
    drv(1'b0, 1'b1, 1'b0, 4'b0001);
    chk("en0_valid", int'(valid), 0);
    chk("en0_dout", int'(Dout), 6);
    chk("en0_err_cnt", int'(err_cnt), 15);
    drv(1'b1, 1'b1, 1'b1, 4'b0001);
    chk("clr_valid", int'(valid), 0);
    chk("clr_err_cnt", int'(err_cnt), 0);
    chk("clr_locked", int'(locked), 0);
    chk("clr_dout", int'(Dout), 6);
    smp(4'b0011);
    smp(4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", int'(Dout), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_dir", int'(dir), 0);
    chk("arst_err_cnt", int'(err_cnt), 0);
    chk("arst_locked", int'(locked), 0);
    #1 rst_n = 1'b1;
    smp(4'b0110);
    chk("post_rst_dout", int'(Dout), 4);
    chk("post_rst_step_err", int'(step_err), 0);
    chk("post_rst_locked", int'(locked), 1);
    drv(1'b0, 1'b0, 1'b0, 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
